// File: rtl/stripes_pkg.sv
// Shared constants and types for the Stripes bit-serial activation path.
package stripes_pkg;

  localparam int N       = 16;
  localparam int LANES   = 16;
  localparam int BIT_IDX = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  typedef logic [LANES*N-1:0] brick_t;

endpackage

// File: rtl/serial_lane.sv
// One serial lane: an N-bit arithmetic shift register emitting its LSB each beat.
module serial_lane #(
  parameter int N       = 16,
  parameter int BIT_IDX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               shift,
  input  logic [N-1:0]       word,
  input  logic [BIT_IDX-1:0] offset,
  output logic               lsb
);

  logic [N-1:0] sreg;

  // Arithmetic shifts replicate the sign bit, so beats past bit N-1 emit sign extension.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= $signed(word) >>> offset;
    end else if (shift) begin
      sreg <= {sreg[N-1], sreg[N-1:1]};
    end
  end

  assign lsb = sreg[0];

endmodule

// File: rtl/bit_serializer.sv
// Transposes a brick of LANES parallel words into LSB-first bit-serial beats.
module bit_serializer
  import stripes_pkg::*;
#(
  parameter int N       = stripes_pkg::N,
  parameter int LANES   = stripes_pkg::LANES,
  parameter int BIT_IDX = stripes_pkg::BIT_IDX
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [LANES*N-1:0] i_data,
  input  logic [BIT_IDX-1:0] i_prec,
  input  logic [BIT_IDX-1:0] i_offset,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [LANES-1:0]   o_bits,
  output logic               o_first,
  output logic               o_last,
  output logic               o_busy,
  output state_t             dbg_state
);

  // Handshake: a beat transfers on a rising edge where o_valid && i_ready;
  // a brick is accepted on a rising edge where i_valid && o_ready.

  state_t             state_q, state_d;
  logic [BIT_IDX-1:0] cnt_q, cnt_d;
  logic [BIT_IDX-1:0] prec_q, prec_d;
  logic [LANES-1:0]   lane_bits;
  logic               xfer;
  logic               accept;
  logic               lane_shift;

  assign o_valid = (state_q == ST_SHIFT);
  assign o_busy  = (state_q == ST_SHIFT);
  assign o_first = o_valid && (cnt_q == '0);
  assign o_last  = o_valid && (cnt_q == prec_q);
  assign xfer    = o_valid && i_ready;
  // Ready during the last transferring beat lets the next brick follow with no bubble.
  assign o_ready = (state_q == ST_IDLE) || (xfer && o_last);
  assign accept  = i_valid && o_ready;
  assign lane_shift = xfer && !accept;
  assign o_bits  = o_valid ? lane_bits : '0;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      prec_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prec_q  <= prec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prec_d  = prec_q;
    if (accept) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
      prec_d  = i_prec;
    end else if (xfer) begin
      if (o_last) begin
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // The offset is consumed by the preload shift, so each lane holds it implicitly.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    serial_lane #(
      .N       (N),
      .BIT_IDX (BIT_IDX)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (accept),
      .shift  (lane_shift),
      .word   (i_data[k*N +: N]),
      .offset (i_offset),
      .lsb    (lane_bits[k])
    );
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: directed bricks, queued expected beats, monitor.
module tb_bit_serializer;
  import stripes_pkg::*;

  localparam int EW = LANES + 2;

  logic               clk;
  logic               rst_n;
  logic               i_valid;
  logic               o_ready;
  brick_t             i_data;
  logic [BIT_IDX-1:0] i_prec;
  logic [BIT_IDX-1:0] i_offset;
  logic               o_valid;
  logic               i_ready;
  logic [LANES-1:0]   o_bits;
  logic               o_first;
  logic               o_last;
  logic               o_busy;
  state_t             dbg_state;

  bit_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data    (i_data),
    .i_prec    (i_prec),
    .i_offset  (i_offset),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_bits    (o_bits),
    .o_first   (o_first),
    .o_last    (o_last),
    .o_busy    (o_busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic          log_bit[$];
  logic          log_first[$];
  logic          log_last[$];
  logic          log_rdy[$];
  int            log_cyc[$];
  int            tests = 0;
  int            fails = 0;
  int            stall_checks = 0;
  int            cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] exp_beat(input brick_t d, input logic [BIT_IDX-1:0] p,
                                             input logic [BIT_IDX-1:0] off, input int b);
    logic [LANES-1:0] bits;
    int idx;
    idx = int'(off) + b;
    for (int k = 0; k < LANES; k++)
      bits[k] = (idx > N-1) ? d[k*N + N-1] : d[k*N + idx];
    return {(b == 0), (b == int'(p)), bits};
  endfunction

  function automatic logic [15:0] pack_q(input logic q[$]);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < q.size() && i < 16; i++) v[i] = q[i];
    return v;
  endfunction

  task automatic clear_logs();
    log_bit.delete(); log_first.delete(); log_last.delete();
    log_rdy.delete(); log_cyc.delete();
    stall_checks = 0;
  endtask

  // ---------------- driver tasks (start and end just after a falling edge) ----------------
  task automatic send(input brick_t d, input logic [BIT_IDX-1:0] p, input logic [BIT_IDX-1:0] off);
    bit done;
    done = 1'b0;
    i_valid = 1'b1; i_data = d; i_prec = p; i_offset = off;
    for (int n = 0; n < 100 && !done; n++) begin
      #1;
      if (o_ready) begin
        for (int b = 0; b <= int'(p); b++) exp_q.push_back(exp_beat(d, p, off, b));
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL send_timeout: o_ready never rose, got 0 expected 1");
      i_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_valid) && n < 300) begin
      @(negedge clk); #3; n++;
    end
    if (n >= 300) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d beats left expected 0", exp_q.size());
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] cur, prev_cur;
    logic          prev_valid, prev_ready, have_prev;
    have_prev = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; prev_cur = '0;
    forever begin
      @(negedge clk); #2;
      cyc++;
      if (!rst_n) begin
        have_prev = 1'b0;
        continue;
      end
      cur = {o_first, o_last, o_bits};
      if (have_prev && prev_valid && !prev_ready && o_valid) begin
        check("stall_hold", 64'(cur), 64'(prev_cur));
        stall_checks++;
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: got 0x%0h expected none", cur);
        end else begin
          check("beat", 64'(cur), 64'(exp_q.pop_front()));
        end
        log_bit.push_back(o_bits[0]);
        log_first.push_back(o_first);
        log_last.push_back(o_last);
        log_rdy.push_back(o_ready);
        log_cyc.push_back(cyc);
      end
      prev_cur = cur; prev_valid = o_valid; prev_ready = i_ready; have_prev = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    brick_t d, d2;
    rst_n = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_data = '0; i_prec = '0; i_offset = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_bits",  64'(o_bits),  64'd0);
    check("rst_first_last", 64'({o_first, o_last}), 64'd0);
    check("rst_busy",  64'(o_busy),  64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("post_rst_ready", 64'(o_ready), 64'd1);
    @(negedge clk);

    // Basic: lane0 = 0x00A5, prec 7, offset 0
    clear_logs();
    d = '0; d[15:0] = 16'h00A5;
    send(d, 4'd7, 4'd0);
    i_valid = 1'b0;
    #1 check("basic_busy", 64'(o_busy), 64'd1);
    wait_drain();
    check("basic_count", 64'(log_bit.size()), 64'd8);
    check("basic_bits",  64'(pack_q(log_bit)),   64'h00A5);
    check("basic_first", 64'(pack_q(log_first)), 64'h0001);
    check("basic_last",  64'(pack_q(log_last)),  64'h0080);
    check("basic_ready", 64'(pack_q(log_rdy)),   64'h0080);
    if (log_cyc.size() == 8) check("basic_span", 64'(log_cyc[7] - log_cyc[0]), 64'd7);
    check("basic_idle_busy", 64'(o_busy), 64'd0);

    // Offset / sign extension
    @(negedge clk);
    clear_logs();
    d = '0; d[15:0] = 16'hF000;
    for (int k = 1; k < LANES; k++) d[k*N +: N] = 16'(k * 16'h1357 + 16'h0ACE);
    send(d, 4'd5, 4'd12);
    i_valid = 1'b0;
    wait_drain();
    check("sext_neg_bits", 64'(pack_q(log_bit)), 64'h003F);
    @(negedge clk);
    clear_logs();
    d[15:0] = 16'h7000;
    send(d, 4'd5, 4'd12);
    i_valid = 1'b0;
    wait_drain();
    check("sext_pos_bits", 64'(pack_q(log_bit)), 64'h0007);

    // Back-to-back, prec 3 each
    @(negedge clk);
    clear_logs();
    d = '0; d2 = '0;
    for (int k = 1; k < LANES; k++) begin
      d[k*N +: N]  = 16'(k * 16'h0911 + 16'h00A3);
      d2[k*N +: N] = 16'(k * 16'h2F05 + 16'h8001);
    end
    d[15:0] = 16'h0006; d2[15:0] = 16'h0012;
    send(d, 4'd3, 4'd0);
    send(d2, 4'd3, 4'd1);
    i_valid = 1'b0;
    wait_drain();
    check("b2b_count", 64'(log_bit.size()), 64'd8);
    check("b2b_bits",  64'(pack_q(log_bit)),   64'h0096);
    check("b2b_first", 64'(pack_q(log_first)), 64'h0011);
    check("b2b_last",  64'(pack_q(log_last)),  64'h0088);
    if (log_cyc.size() == 8) check("b2b_no_gap", 64'(log_cyc[7] - log_cyc[0]), 64'd7);

    // Backpressure: stall three cycles on beat 2 of prec 4
    @(negedge clk);
    clear_logs();
    d = '0; d[15:0] = 16'h0015;
    for (int k = 1; k < LANES; k++) d[k*N +: N] = 16'(16'hC3A5 >> (k % 5));
    send(d, 4'd4, 4'd0);
    i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_ready = 1'b0;
    repeat (3) @(negedge clk);
    i_ready = 1'b1;
    wait_drain();
    check("bp_stall_checks", 64'(stall_checks), 64'd3);
    check("bp_count", 64'(log_bit.size()), 64'd5);
    check("bp_bits",  64'(pack_q(log_bit)), 64'h0015);

    // Parameter latching, then prec 0
    @(negedge clk);
    clear_logs();
    d = '0; d[15:0] = 16'h000B;
    send(d, 4'd3, 4'd0);
    i_valid = 1'b0; i_prec = 4'd0; i_offset = 4'd8;
    wait_drain();
    check("latch_count", 64'(log_bit.size()), 64'd4);
    check("latch_bits",  64'(pack_q(log_bit)), 64'h000B);
    @(negedge clk);
    clear_logs();
    d = '0; d[15:0] = 16'h0001; d[31:16] = 16'h8000;
    send(d, 4'd0, 4'd0);
    i_valid = 1'b0;
    wait_drain();
    check("p0_count", 64'(log_bit.size()), 64'd1);
    check("p0_first_last", 64'({pack_q(log_first), pack_q(log_last)}), 64'h0001_0001);

    // Reset mid-brick on beat 3 of prec 15
    @(negedge clk);
    clear_logs();
    d = '0; d[15:0] = 16'hFFFF;
    send(d, 4'd15, 4'd0);
    i_valid = 1'b0;
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_valid", 64'(o_valid), 64'd0);
    check("midrst_busy",  64'(o_busy),  64'd0);
    check("midrst_outs",  64'({o_first, o_last, o_bits}), 64'd0);
    @(negedge clk); #3 rst_n = 1'b1;
    @(negedge clk); #1;
    check("midrst_ready", 64'(o_ready), 64'd1);
    check("midrst_idle",  64'(o_valid), 64'd0);
    @(negedge clk);
    clear_logs();
    d = '0; d[15:0] = 16'h0003;
    send(d, 4'd1, 4'd0);
    i_valid = 1'b0;
    wait_drain();
    check("midrst_new_bits",  64'(pack_q(log_bit)),   64'h0003);
    check("midrst_new_first", 64'(pack_q(log_first)), 64'h0001);
    check("midrst_new_last",  64'(pack_q(log_last)),  64'h0002);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Consumes the rounded, clamped parallel activations produced by the rounder and transposes them into bit-serial form for the Stripes serial inner-product units.
- Accepts one brick of LANES words, each N bits, and emits one bit per lane per cycle over a programmable number of bits, LSB first, starting at a programmable bit offset.
- Uses ready/valid on both sides and supports back-to-back bricks with no bubble cycle.

Parameters:
- N, 16, word width in bits (matches rounder N).
- LANES, 16, words per brick, i.e. parallel serial lanes.
- BIT_IDX, 4, width of the offset and precision fields (2**BIT_IDX == N).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input brick valid.
- o_ready  out  1  block can accept a brick this cycle.
- i_data  in  LANES*N  brick; lane k occupies bits [k*N+N-1 : k*N].
- i_prec  in  BIT_IDX  precision minus one; 0..N-1 encodes 1..N bits.
- i_offset  in  BIT_IDX  index of the first bit emitted; same meaning as the rounder offset.
- o_valid  out  1  o_bits valid.
- i_ready  in  1  downstream accepts o_bits.
- o_bits  out  LANES  bit k is the current serial bit of lane k.
- o_first  out  1  current beat is bit 0 of the brick.
- o_last  out  1  current beat is the final bit of the brick.
- o_busy  out  1  a brick is held, not yet fully emitted.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - o_valid, o_bits, o_first, o_last and o_busy go to 0.
  - The internal bit counter and latched prec/offset go to 0.
  - Any partially emitted brick is discarded with no o_last.
  - o_ready is 1 from the first cycle after reset release.
- States:
  - IDLE: no brick held, o_valid=0.
  - SHIFT: brick held, o_valid=1.
- Accept condition: i_valid && o_ready at a rising edge.
  - i_data, i_prec and i_offset are latched together; later changes to i_prec/i_offset do not affect the held brick.
  - The bit counter is cleared and the state moves to SHIFT.
- Latency: a brick accepted at edge t presents its first beat (o_first=1) in the cycle after t.
- o_ready is combinational: (state==IDLE) || (o_valid && i_ready && o_last).
  - A brick may therefore be accepted on the same edge the previous brick's last beat transfers.
  - The new brick's first beat follows immediately, with zero bubble.
- Beat b (b = 0..prec):
  - o_bits[k] = bit (offset+b) of lane k.
  - If offset+b > N-1, the sign bit (bit N-1) of that lane is emitted instead (two's-complement sign extension).
  - Implement as a per-lane arithmetic right shift: preload word>>>offset, shift by one on each transferred beat.
- Advance: the counter increments only when o_valid && i_ready. While i_ready=0, o_bits, o_first and o_last hold stable.
- o_first = (counter==0) in SHIFT. o_last = (counter==latched prec) in SHIFT.
- When prec=0, o_first and o_last are both 1 on the single beat.
- Last beat transferred with no new brick accepted: return to IDLE, o_valid=0 next cycle.
- Throughput: one brick per (prec+1) cycles when i_valid and i_ready are held high.
- o_busy = (state==SHIFT).

Decomposition:
- Shared package stripes_pkg holds:
  - constants N, LANES, BIT_IDX;
  - a state enumeration type for IDLE/SHIFT;
  - a typedef for the brick vector, LANES*N bits.
- One sub-module, serial_lane, instantiated LANES times.
  - Contains the N-bit arithmetic shift register: preload with shift by offset, shift-by-one enable, LSB output.
- The top level holds the FSM, bit counter, latched prec, and the handshake logic.

Test Plan:
- Basic:
  - Stimulus: lane0=16'h00A5, all other lanes 0, prec=7, offset=0, i_ready=1.
  - Required: lane0 emits 1,0,1,0,0,1,0,1 over 8 consecutive beats; o_first on beat 0, o_last on beat 7; o_ready=1 only during beat 7.
- Offset and sign extension:
  - Stimulus: lane0=16'hF000 (negative), prec=5, offset=12.
  - Required: beats 0-3 emit 1 (bits 12-15); beats 4-5 emit 1 (sign-extended).
  - Repeat with lane0=16'h7000: beats 0-2 emit 1, beat 3 emits 0, beats 4-5 emit 0.
- Back-to-back:
  - Stimulus: two bricks presented continuously, each with prec=3.
  - Required: 8 consecutive valid beats with no gap; the second o_first lands in the cycle immediately after the first o_last.
- Backpressure:
  - Stimulus: i_ready=0 for 3 cycles during beat 2 of prec=4.
  - Required: o_bits, o_first and o_last are stable for all 3 stalled cycles; the stream resumes at beat 2, with 5 beats transferred in total.
- Parameter latching and prec=0:
  - Stimulus: change i_prec/i_offset after accept; then send a brick with prec=0.
  - Required: the held brick keeps the originally latched values; the prec=0 brick produces a single beat with o_first=o_last=1.
- Reset mid-brick:
  - Stimulus: assert rst_n=0 during beat 3 of prec=15.
  - Required: o_valid=0 immediately (asynchronous). After release, o_ready=1, and a new brick starts cleanly with o_first=1 at beat 0.
